// File: rtl/spi_ram.sv
// spi_ram - byte RAM that acts as the command target of the SPI slave.
//
// Each 10-bit frame carries an opcode in [9:8] and a payload in [7:0]:
//   00 WR_ADDR : load the write address
//   01 WR_DATA : write the payload to mem[wr_addr]
//   10 RD_ADDR : load the read address
//   11 RD_DATA : return mem[rd_addr] on tx_data and raise tx_valid
//
// Out-of-range addresses (>= MEM_DEPTH) are handled as follows:
//   - writes to them are dropped;
//   - reads from them return 8'h00.
//
// Optional feature, macro SPI_RAM_AUTOINC_EN:
//   Each data command post-increments its address register, modulo MEM_DEPTH.
//   This allows burst transfers without re-sending the address.
//
// Ports:
//   clk      in   clock, posedge
//   rst_n    in   asynchronous active-low reset (memory contents are kept)
//   rx_data  in   [9:0] command frame
//   rx_valid in   single-cycle frame strobe
//   tx_data  out  [7:0] read result, held after tx_valid drops
//   tx_valid out  level: high from a RD_DATA until the next non-read frame
module spi_ram #(
  parameter int MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  logic [7:0]    r_wr_addr;
  logic [7:0]    r_rd_addr;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic [7:0]    r_mem [0:MEM_DEPTH-1];

  logic [1:0]    w_op;
  logic [7:0]    w_payload;
  logic          w_wr_in_range;
  logic          w_rd_in_range;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic [7:0]    w_rd_word;

  assign w_op      = rx_data[9:8];
  assign w_payload = rx_data[7:0];

  // 9-bit compare so MEM_DEPTH = 256 does not overflow the address width.
  assign w_wr_in_range = ({1'b0, r_wr_addr} < 9'(MEM_DEPTH));
  assign w_rd_in_range = ({1'b0, r_rd_addr} < 9'(MEM_DEPTH));
  assign w_wr_idx      = r_wr_addr[AW-1:0];
  assign w_rd_idx      = r_rd_addr[AW-1:0];
  assign w_rd_word     = w_rd_in_range ? r_mem[w_rd_idx] : 8'h00;

`ifdef SPI_RAM_AUTOINC_EN
  // The last legal address and any out-of-range address both wrap to 0.
  logic [7:0] w_wr_next;
  logic [7:0] w_rd_next;
  assign w_wr_next = (w_wr_in_range && ({1'b0, r_wr_addr} != 9'(MEM_DEPTH - 1)))
                     ? r_wr_addr + 8'd1 : 8'd0;
  assign w_rd_next = (w_rd_in_range && ({1'b0, r_rd_addr} != 9'(MEM_DEPTH - 1)))
                     ? r_rd_addr + 8'd1 : 8'd0;
`endif

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr  <= 8'h00;
      r_rd_addr  <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else if (rx_valid) begin
      case (w_op)
        OP_WR_ADDR: begin
          r_wr_addr  <= w_payload;
          r_tx_valid <= 1'b0;
        end
        OP_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
          r_wr_addr  <= w_wr_next;
`endif
          r_tx_valid <= 1'b0;
        end
        OP_RD_ADDR: begin
          r_rd_addr  <= w_payload;
          r_tx_valid <= 1'b0;
        end
        default: begin
          r_tx_data  <= w_rd_word;
          r_tx_valid <= 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
          r_rd_addr  <= w_rd_next;
`endif
        end
      endcase
    end
  end

  // Storage array: no reset, so contents survive rst_n
  always_ff @(posedge clk) begin
    if (rx_valid && (w_op == OP_WR_DATA) && w_wr_in_range) begin
      r_mem[w_wr_idx] <= w_payload;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_spi_ram.sv
// Testbench for spi_ram.
// Two instances share the same frame stream:
//   - one at the default depth (256);
//   - one at MEM_DEPTH = 16, which exercises out-of-range addresses.
// A behavioural model predicts every result. Read results are queued when
// RD_DATA is driven and compared after the accepting edge.
module tb_spi_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1;

  spi_ram dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data0),
    .tx_valid (tx_valid0)
  );

  spi_ram #(.MEM_DEPTH(16)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data1),
    .tx_valid (tx_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model state, indexed by instance (0 = depth 256, 1 = depth 16)
  int         depth [2] = '{256, 16};
  logic [7:0] m_mem [2][256];
  bit         m_wrt [2][256];
  int         m_wa [2];
  int         m_ra [2];
  logic [7:0] m_txd [2];
  bit         m_txd_known [2];
  bit         m_txv [2];

  typedef struct {
    int         k;
    logic [7:0] d;
    bit         known;
  } exp_t;
  exp_t sbq[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wa[k] = 0; m_ra[k] = 0;
      m_txd[k] = 8'h00; m_txd_known[k] = 1'b1; m_txv[k] = 1'b0;
    end
  endtask

  function automatic int next_addr(input int a, input int d);
`ifdef SPI_RAM_AUTOINC_EN
    return (a + 1 >= d) ? 0 : a + 1;
`else
    return a;
`endif
  endfunction

  task automatic model_frame(input int k, input logic [9:0] f);
    logic [7:0] p;
    exp_t e;
    p = f[7:0];
    case (f[9:8])
      2'b00: begin m_wa[k] = int'(p); m_txv[k] = 1'b0; end
      2'b01: begin
        if (m_wa[k] < depth[k]) begin
          m_mem[k][m_wa[k]] = p;
          m_wrt[k][m_wa[k]] = 1'b1;
        end
        m_wa[k] = next_addr(m_wa[k], depth[k]);
        m_txv[k] = 1'b0;
      end
      2'b10: begin m_ra[k] = int'(p); m_txv[k] = 1'b0; end
      default: begin
        e.k = k;
        if (m_ra[k] < depth[k]) begin
          e.d = m_mem[k][m_ra[k]];
          e.known = m_wrt[k][m_ra[k]];
        end else begin
          e.d = 8'h00;
          e.known = 1'b1;
        end
        sbq.push_back(e);
        m_txd[k] = e.d; m_txd_known[k] = e.known; m_txv[k] = 1'b1;
        m_ra[k] = next_addr(m_ra[k], depth[k]);
      end
    endcase
  endtask

  task automatic check_levels(input string tag);
    chk({tag, "_vld0"}, tx_valid0, m_txv[0]);
    chk({tag, "_vld1"}, tx_valid1, m_txv[1]);
    if (m_txd_known[0]) chk({tag, "_dat0"}, tx_data0, m_txd[0]);
    if (m_txd_known[1]) chk({tag, "_dat1"}, tx_data1, m_txd[1]);
  endtask

  task automatic send(input string tag, input logic [9:0] f);
    exp_t e;
    logic [7:0] got;
    @(negedge clk);
    rx_data  = f;
    rx_valid = 1'b1;
    model_frame(0, f);
    model_frame(1, f);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = (e.k == 0) ? tx_data0 : tx_data1;
      if (e.known) chk($sformatf("%s_rd%0d", tag, e.k), got, e.d);
    end
    check_levels(tag);
  endtask

  // Idle cycles with junk on rx_data: nothing may change.
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 10'($urandom_range(0, 1023));
      @(posedge clk);
      #1;
      check_levels(tag);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) begin
        m_wrt[k][a] = 1'b0;
        m_mem[k][a] = 8'h00;
      end
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 10'h000;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_levels("reset");
    idle("idle_rst", 5);

    // Seed address 0 so later reads of it are defined in both depths
    send("seed_wa", 10'h0_00);
    send("seed_wd", 10'h1_A5);

    // Write then read
    send("wa_2a", 10'h0_2A);
    send("wd_5c", 10'h1_5C);
    send("ra_2a", 10'h2_2A);
    send("rd_2a", 10'h3_00);
    idle("hold", 3);

    // Back-to-back reads
    send("rd_b2b1", 10'h3_00);
    send("rd_b2b2", 10'h3_00);

    // Out of range for depth 16; the WR_ADDR also clears tx_valid
    send("wa_20", 10'h0_20);
    send("wd_ff", 10'h1_FF);
    send("ra_20", 10'h2_20);
    send("rd_20", 10'h3_00);
    send("ra_00", 10'h2_00);
    send("rd_00", 10'h3_00);

    // Burst across the top of the address space
    send("wa_fe", 10'h0_FE);
    send("wd_11", 10'h1_11);
    send("wd_22", 10'h1_22);
    send("wd_33", 10'h1_33);
    send("ra_fe", 10'h2_FE);
    send("rd_b1", 10'h3_00);
    send("rd_b2", 10'h3_00);
    send("rd_b3", 10'h3_00);
    send("ra_wrap", 10'h2_00);
    send("rd_wrap", 10'h3_00);

    // Reset mid-operation with tx_valid high
    send("ra_pre", 10'h2_2A);
    send("rd_pre", 10'h3_00);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_levels("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release: write to wr_addr 0, then read rd_addr 0
    send("post_wd", 10'h1_77);
    send("post_rd", 10'h3_00);
    send("post_ra", 10'h2_2A);
    send("post_rd2a", 10'h3_00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
